// File: rtl/clock_time_counter_if.sv
// Snapshot handshake between the time counter and the OLED text renderer.
// master drives the digits and upd_valid; slave returns upd_ready.
interface clock_time_counter_if;
    logic [7:0] disp_hh;
    logic [7:0] disp_mm;
    logic [7:0] disp_ss;
    logic       upd_valid;
    logic       upd_ready;

    modport master (
        output disp_hh, disp_mm, disp_ss, upd_valid,
        input  upd_ready
    );

    modport slave (
        input  disp_hh, disp_mm, disp_ss, upd_valid,
        output upd_ready
    );
endinterface

// File: rtl/clock_time_counter.sv
// BCD HH:MM:SS time-of-day counter fed by the 1 Hz divider, with a valid/ready snapshot port.
// Optional alarm compare is compiled in when the ALARM_EN macro is defined.
module clock_time_counter #(
    parameter int unsigned HOUR_MAX    = 23,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       clk_1Hz,
    input  logic       run,
    input  logic       clear,
    input  logic       set_en,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic       set_err,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
`ifdef ALARM_EN
    input  logic [7:0] al_hh,
    input  logic [7:0] al_mm,
    input  logic [7:0] al_ss,
    input  logic       al_arm,
    output logic       alarm,
`endif
    clock_time_counter_if.master upd
);

    localparam logic [7:0] HOUR_MAX_BCD = 8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));

    // Wraps to 00 at max_v, otherwise a plain BCD increment of the two digits.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- input sampling
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   hist_q;
    logic                   primed_q;
    logic                   tick_q;
    logic                   sync_out;
    logic                   tick_d;

    assign sync_out = sync_q[SYNC_STAGES-1];
    // A high level seen straight out of reset is not an edge: the chain must first
    // carry real samples and show a low before any rise counts.
    assign tick_d   = sync_out & ~hist_q & primed_q;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            fill_q   <= '0;
            hist_q   <= 1'b0;
            primed_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_1Hz};
            fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            hist_q   <= sync_out;
            primed_q <= primed_q | (fill_q[SYNC_STAGES-1] & ~sync_out);
            tick_q   <= tick_d;
        end
    end

    // ---------------------------------------------------------------- time count
    logic [7:0] hh_q, mm_q, ss_q;
    logic [7:0] hh_d, mm_d, ss_d;
    logic [7:0] hh_inc, mm_inc, ss_inc;
    logic       set_ok;
    logic       change;
    logic       set_err_q, set_err_d;

    always_comb begin
        set_ok = (set_hh[7:4] <= 4'd9) && (set_hh[3:0] <= 4'd9) &&
                 (set_mm[7:4] <= 4'd9) && (set_mm[3:0] <= 4'd9) &&
                 (set_ss[7:4] <= 4'd9) && (set_ss[3:0] <= 4'd9) &&
                 (set_ss <= 8'h59) && (set_mm <= 8'h59) && (set_hh <= HOUR_MAX_BCD);
    end

    always_comb begin
        ss_inc    = bcd_inc(ss_q, 8'h59);
        mm_inc    = bcd_inc(mm_q, 8'h59);
        hh_inc    = bcd_inc(hh_q, HOUR_MAX_BCD);
        hh_d      = hh_q;
        mm_d      = mm_q;
        ss_d      = ss_q;
        change    = 1'b0;
        set_err_d = set_en & ~clear & ~set_ok;
        if (clear) begin
            hh_d   = 8'h00;
            mm_d   = 8'h00;
            ss_d   = 8'h00;
            change = 1'b1;
        end else if (set_en && set_ok) begin
            hh_d   = set_hh;
            mm_d   = set_mm;
            ss_d   = set_ss;
            change = 1'b1;
        end else if (tick_q && run) begin
            ss_d   = ss_inc;
            change = 1'b1;
            if (ss_q == 8'h59) begin
                mm_d = mm_inc;
                if (mm_q == 8'h59) begin
                    hh_d = hh_inc;
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            hh_q      <= 8'h00;
            mm_q      <= 8'h00;
            ss_q      <= 8'h00;
            set_err_q <= 1'b0;
        end else begin
            hh_q      <= hh_d;
            mm_q      <= mm_d;
            ss_q      <= ss_d;
            set_err_q <= set_err_d;
        end
    end

    assign hh_bcd  = hh_q;
    assign mm_bcd  = mm_q;
    assign ss_bcd  = ss_q;
    assign set_err = set_err_q;

    // ---------------------------------------------------------------- snapshot handshake
    logic       pending_q, pending_d;
    logic       valid_q, valid_d;
    logic       load;
    logic [7:0] disp_hh_q, disp_mm_q, disp_ss_q;
    logic [7:0] disp_hh_d, disp_mm_d, disp_ss_d;

    // The load copies the pre-change live value; a change in the same cycle re-arms pending.
    always_comb begin
        load      = pending_q & (~valid_q | upd.upd_ready);
        pending_d = change | (pending_q & ~load);
        valid_d   = valid_q;
        disp_hh_d = disp_hh_q;
        disp_mm_d = disp_mm_q;
        disp_ss_d = disp_ss_q;
        if (load) begin
            valid_d   = 1'b1;
            disp_hh_d = hh_q;
            disp_mm_d = mm_q;
            disp_ss_d = ss_q;
        end else if (upd.upd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            disp_hh_q <= 8'h00;
            disp_mm_q <= 8'h00;
            disp_ss_q <= 8'h00;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            disp_hh_q <= disp_hh_d;
            disp_mm_q <= disp_mm_d;
            disp_ss_q <= disp_ss_d;
        end
    end

    assign upd.upd_valid = valid_q;
    assign upd.disp_hh   = disp_hh_q;
    assign upd.disp_mm   = disp_mm_q;
    assign upd.disp_ss   = disp_ss_q;

`ifdef ALARM_EN
    // ---------------------------------------------------------------- alarm
    logic alarm_q, alarm_d;
    logic hit;

    // Fires only on a change into equality, so sitting on the alarm time never re-fires.
    always_comb begin
        hit     = change && ({hh_d, mm_d, ss_d} == {al_hh, al_mm, al_ss}) &&
                  ({hh_q, mm_q, ss_q} != {al_hh, al_mm, al_ss});
        alarm_d = alarm_q;
        if (!al_arm) begin
            alarm_d = 1'b0;
        end else if (hit) begin
            alarm_d = 1'b1;
        end else if (clear) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench for clock_time_counter: directed scenarios plus randomized traffic,
// all compared against a seconds-based reference model of the clock and snapshot port.
module tb_clock_time_counter;

    localparam int unsigned HOUR_MAX = 23;
    localparam int          DAY      = (HOUR_MAX + 1) * 3600;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       clk_1Hz;
    logic       run;
    logic       clear;
    logic       set_en;
    logic [7:0] set_hh, set_mm, set_ss;
    logic       set_err;
    logic [7:0] hh_bcd, mm_bcd, ss_bcd;
`ifdef ALARM_EN
    logic [7:0] al_hh, al_mm, al_ss;
    logic       al_arm;
    logic       alarm;
`endif

    clock_time_counter_if upd_if ();

    clock_time_counter #(
        .HOUR_MAX   (HOUR_MAX),
        .SYNC_STAGES(2)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .clk_1Hz   (clk_1Hz),
        .run       (run),
        .clear     (clear),
        .set_en    (set_en),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .set_ss    (set_ss),
        .set_err   (set_err),
        .hh_bcd    (hh_bcd),
        .mm_bcd    (mm_bcd),
        .ss_bcd    (ss_bcd),
`ifdef ALARM_EN
        .al_hh     (al_hh),
        .al_mm     (al_mm),
        .al_ss     (al_ss),
        .al_arm    (al_arm),
        .alarm     (alarm),
`endif
        .upd       (upd_if)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    int m_secs;
    int m_disp;
    bit m_pend;
    bit m_vld;
    bit m_err;
    bit m_alarm;
    bit s_hist[$];

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int bcd_dec(input logic [7:0] v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_disp  = 0;
        m_pend  = 0;
        m_vld   = 0;
        m_err   = 0;
        m_alarm = 0;
        s_hist.delete();
    endtask

    // One rising clock edge worth of behaviour, from the inputs held across that edge.
    task automatic model_edge();
        int  k, hd, md, sd, old;
        bit  tick, ok, chg, load;
        s_hist.push_back(clk_1Hz);
        k    = s_hist.size();
        // A rise sampled at edge N is counted at edge N+3.
        tick = (k >= 5) && s_hist[k-4] && !s_hist[k-5];
        hd   = bcd_dec(set_hh);
        md   = bcd_dec(set_mm);
        sd   = bcd_dec(set_ss);
        ok   = hd >= 0 && md >= 0 && sd >= 0 && hd <= int'(HOUR_MAX) && md <= 59 && sd <= 59;
        old  = m_secs;
        chg  = 0;
        if (clear) begin
            m_secs = 0;
            chg    = 1;
        end else if (set_en && ok) begin
            m_secs = hd * 3600 + md * 60 + sd;
            chg    = 1;
        end else if (tick && run) begin
            m_secs = (m_secs + 1) % DAY;
            chg    = 1;
        end
        m_err = set_en && !clear && !ok;
        load  = m_pend && (!m_vld || upd_if.upd_ready);
        if (load) begin
            m_disp = old;
            m_vld  = 1;
            m_pend = chg;
        end else begin
            if (upd_if.upd_ready) m_vld = 0;
            m_pend = m_pend | chg;
        end
`ifdef ALARM_EN
        if (!al_arm) m_alarm = 0;
        else if (chg && to_bcd(m_secs) == {al_hh, al_mm, al_ss} &&
                 to_bcd(old) != {al_hh, al_mm, al_ss}) m_alarm = 1;
        else if (clear) m_alarm = 0;
`endif
    endtask

    task automatic compare_all();
        check("live_time", {hh_bcd, mm_bcd, ss_bcd}, to_bcd(m_secs));
        check("disp_time", {upd_if.disp_hh, upd_if.disp_mm, upd_if.disp_ss}, to_bcd(m_disp));
        check("upd_valid", upd_if.upd_valid, m_vld);
        check("set_err", set_err, m_err);
`ifdef ALARM_EN
        check("alarm", alarm, m_alarm);
`endif
    endtask

    // Inputs change on the falling edge; results are compared on the next falling edge.
    task automatic step();
        @(posedge clk_100MHz);
        model_edge();
        @(negedge clk_100MHz);
        compare_all();
        clear  = 1'b0;
        set_en = 1'b0;
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_en = 1'b1;
        set_hh = h;
        set_mm = m;
        set_ss = s;
        step();
    endtask

    task automatic pulse_1hz(input logic [7:0] prev_ss, input logic [7:0] exp_ss,
                             input bit chk_valid);
        clk_1Hz = 1'b1;
        repeat (3) step();
        check("tick_early", ss_bcd, prev_ss);
        step();
        check("tick_edge", ss_bcd, exp_ss);
        if (chk_valid) begin
            step();
            check("valid_after_change", upd_if.upd_valid, 1'b1);
            check("disp_after_change", upd_if.disp_ss, exp_ss);
        end
        repeat (2) step();
        clk_1Hz = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end

    logic [7:0] bad_vals [3][3];

    initial begin
        reset            = 1'b1;
        clk_1Hz          = 1'b0;
        run              = 1'b0;
        clear            = 1'b0;
        set_en           = 1'b0;
        set_hh           = 8'h00;
        set_mm           = 8'h00;
        set_ss           = 8'h00;
        upd_if.upd_ready = 1'b1;
`ifdef ALARM_EN
        al_hh  = 8'h00;
        al_mm  = 8'h01;
        al_ss  = 8'h00;
        al_arm = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk_100MHz);
        check("rst_time", {hh_bcd, mm_bcd, ss_bcd}, 24'h000000);
        check("rst_valid", upd_if.upd_valid, 1'b0);
        check("rst_disp", {upd_if.disp_hh, upd_if.disp_mm, upd_if.disp_ss}, 24'h000000);
        check("rst_set_err", set_err, 1'b0);
        reset = 1'b0;
        run   = 1'b1;
        repeat (4) step();

        // Three seconds from reset.
        for (int i = 0; i < 3; i++) pulse_1hz(8'(i), 8'(i + 1), 1'b0);
        check("three_secs", {hh_bcd, mm_bcd, ss_bcd}, 24'h000003);

        // Day wrap in a single edge.
        do_set(8'h23, 8'h59, 8'h58);
        check("set_load", {hh_bcd, mm_bcd, ss_bcd}, 24'h235958);
        pulse_1hz(8'h58, 8'h59, 1'b1);
        check("pre_wrap", {hh_bcd, mm_bcd, ss_bcd}, 24'h235959);
        pulse_1hz(8'h59, 8'h00, 1'b1);
        check("day_wrap", {hh_bcd, mm_bcd, ss_bcd}, 24'h000000);

        // Rejected sets leave time unchanged and pulse set_err once.
        do_set(8'h12, 8'h34, 8'h56);
        bad_vals[0] = '{8'h12, 8'h34, 8'h5A};
        bad_vals[1] = '{8'h12, 8'h60, 8'h56};
        bad_vals[2] = '{8'h24, 8'h34, 8'h56};
        for (int i = 0; i < 3; i++) begin
            do_set(bad_vals[i][0], bad_vals[i][1], bad_vals[i][2]);
            check("bad_set_time", {hh_bcd, mm_bcd, ss_bcd}, 24'h123456);
            check("bad_set_err", set_err, 1'b1);
            step();
            check("bad_set_err_end", set_err, 1'b0);
        end
        clear = 1'b1;
        do_set(8'h11, 8'h11, 8'h11);
        check("clear_wins", {hh_bcd, mm_bcd, ss_bcd}, 24'h000000);
        check("clear_wins_err", set_err, 1'b0);

        // Stalled renderer sees the first change, then only the latest.
        do_set(8'h00, 8'h00, 8'h10);
        repeat (4) step();
        upd_if.upd_ready = 1'b0;
        pulse_1hz(8'h10, 8'h11, 1'b0);
        pulse_1hz(8'h11, 8'h12, 1'b0);
        pulse_1hz(8'h12, 8'h13, 1'b0);
        check("stall_disp", upd_if.disp_ss, 8'h11);
        check("stall_valid", upd_if.upd_valid, 1'b1);
        upd_if.upd_ready = 1'b1;
        step();
        check("release_disp", upd_if.disp_ss, 8'h13);
        step();
        check("release_valid", upd_if.upd_valid, 1'b0);

`ifdef ALARM_EN
        do_set(8'h00, 8'h00, 8'h59);
        al_arm  = 1'b1;
        clk_1Hz = 1'b1;
        repeat (3) step();
        check("alarm_early", alarm, 1'b0);
        step();
        check("alarm_mm", mm_bcd, 8'h01);
        check("alarm_fire", alarm, 1'b1);
        step();
        clk_1Hz = 1'b0;
        al_arm  = 1'b0;
        step();
        check("alarm_disarm", alarm, 1'b0);
        repeat (4) step();
`endif

        // Reset mid-handshake with clk_1Hz high.
        upd_if.upd_ready = 1'b0;
        clk_1Hz          = 1'b1;
        do_set(8'h07, 8'h08, 8'h09);
        step();
        check("pre_rst_valid", upd_if.upd_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_time", {hh_bcd, mm_bcd, ss_bcd}, 24'h000000);
        check("async_rst_disp", {upd_if.disp_hh, upd_if.disp_mm, upd_if.disp_ss}, 24'h000000);
        check("async_rst_valid", upd_if.upd_valid, 1'b0);
        model_reset();
        @(negedge clk_100MHz);
        reset            = 1'b0;
        upd_if.upd_ready = 1'b1;
        repeat (8) step();
        check("no_tick_after_rst", ss_bcd, 8'h00);
        clk_1Hz = 1'b0;
        repeat (3) step();
        pulse_1hz(8'h00, 8'h01, 1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(3) == 0) clk_1Hz = ~clk_1Hz;
            run              = ($urandom_range(7) != 0);
            upd_if.upd_ready = $urandom_range(1);
            clear            = ($urandom_range(39) == 0);
`ifdef ALARM_EN
            al_arm = ($urandom_range(3) != 0);
`endif
            if ($urandom_range(19) == 0) begin
                set_en = 1'b1;
                if ($urandom_range(1) == 0) begin
                    set_hh = 8'($urandom);
                    set_mm = 8'($urandom);
                    set_ss = 8'($urandom);
                end else begin
                    set_hh = to_bcd($urandom_range(HOUR_MAX) * 3600)[23:16];
                    set_mm = ($urandom_range(1) == 0) ? 8'h59 : 8'h00;
                    set_ss = ($urandom_range(1) == 0) ? 8'h58 : 8'h59;
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
